// File: rtl/motor_rate_ramp_pkg.sv
// Shared types, FSM encodings and slew arithmetic for the motor rate ramp.
package motor_rate_ramp_pkg;

  localparam int BIT_WIDTH_8              = 8;
  localparam int DEFAULT_UPDATE_PERIOD_US = 20000;

  localparam logic [1:0] RAMP_DISARMED = 2'd0;
  localparam logic [1:0] RAMP_ARMING   = 2'd1;
  localparam logic [1:0] RAMP_RUN      = 2'd2;
  localparam logic [1:0] RAMP_STOPPING = 2'd3;

  typedef logic [BIT_WIDTH_8-1:0] rate_t;

  // 9-bit signed difference, so the output never wraps past 0 or 255.
  function automatic rate_t slew_toward(input rate_t cur, input rate_t tgt, input rate_t max_step);
    logic signed [8:0] diff;
    logic signed [8:0] lim;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    lim  = $signed({1'b0, max_step});
    if (diff > lim)
      slew_toward = cur + max_step;
    else if (diff < -lim)
      slew_toward = cur - max_step;
    else
      slew_toward = tgt;
  endfunction

endpackage

// File: rtl/motor_rate_ramp_if.sv
// Command handshake and slewed-rate bus between the command source and the ramp block.
interface motor_rate_ramp_if;
  import motor_rate_ramp_pkg::*;

  logic  cmd_valid;
  logic  cmd_ready;
  rate_t cmd_rate_1;
  rate_t cmd_rate_2;
  rate_t cmd_rate_3;
  rate_t cmd_rate_4;
  rate_t motor_1_rate;
  rate_t motor_2_rate;
  rate_t motor_3_rate;
  rate_t motor_4_rate;
  logic  armed;
  logic  step_tick;

  modport master (
    output cmd_valid, cmd_rate_1, cmd_rate_2, cmd_rate_3, cmd_rate_4,
    input  cmd_ready, motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate, armed, step_tick
  );

  modport slave (
    input  cmd_valid, cmd_rate_1, cmd_rate_2, cmd_rate_3, cmd_rate_4,
    output cmd_ready, motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate, armed, step_tick
  );

endinterface

// File: rtl/motor_rate_ramp_channel.sv
// One slew-limited rate channel: latches a target on load, moves out toward it on step.
// clear drops the target to 0 and wins over a coincident load or step.
module rate_slew_channel
  import motor_rate_ramp_pkg::*;
#(
  parameter int MAX_STEP = 4
) (
  input  logic  us_clk,
  input  logic  resetn,
  input  logic  load,
  input  rate_t target,
  input  logic  step,
  input  logic  clear,
  output rate_t out
);

  localparam rate_t STEP = rate_t'(MAX_STEP);

  rate_t target_q, target_d;
  rate_t out_q, out_d;

  always_comb begin
    target_d = target_q;
    out_d    = out_q;
    if (clear) begin
      target_d = '0;
    end else begin
      if (load) target_d = target;
      if (step) out_d = slew_toward(out_q, target_q, STEP);
    end
  end

  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      target_q <= '0;
      out_q    <= '0;
    end else begin
      target_q <= target_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/motor_rate_ramp.sv
// Arm/disarm sequencer and 4-channel slew limiter feeding the PWM generator.
// Steps once per UPDATE_PERIOD_US cycles; commands are refused during the step cycle and outside RUN.
module motor_rate_ramp
  import motor_rate_ramp_pkg::*;
#(
  parameter int UPDATE_PERIOD_US = DEFAULT_UPDATE_PERIOD_US,
  parameter int MAX_STEP         = 4,
  parameter int ARM_PERIODS      = 100
) (
  input logic               us_clk,
  input logic               resetn,
  input logic               arm_req,
  motor_rate_ramp_if.slave  bus
);

  localparam int              PCW         = (UPDATE_PERIOD_US > 1) ? $clog2(UPDATE_PERIOD_US) : 1;
  localparam int              ACW         = $clog2(ARM_PERIODS + 1);
  localparam logic [PCW-1:0]  PERIOD_LAST = PCW'(UPDATE_PERIOD_US - 1);
  localparam logic [ACW-1:0]  ARM_LAST    = ACW'(ARM_PERIODS - 1);
  localparam rate_t           STEP        = rate_t'(MAX_STEP);

  logic [1:0]     state_q, state_d;
  logic [PCW-1:0] period_cnt_q, period_cnt_d;
  logic [ACW-1:0] arm_cnt_q, arm_cnt_d;
  logic           armed_q, armed_d;

  logic  step_tick, cmd_ready, load, clear, step_en, all_low;
  rate_t cmd_rate [4];
  rate_t rate_out [4];

  assign step_tick    = (period_cnt_q == PERIOD_LAST);
  assign period_cnt_d = step_tick ? '0 : period_cnt_q + PCW'(1);
  assign cmd_ready    = (state_q == RAMP_RUN) && !step_tick;
  assign load         = bus.cmd_valid && cmd_ready;
  assign clear        = (state_q == RAMP_RUN) && !arm_req;
  // A disarm landing on the step cycle suppresses that step.
  assign step_en      = step_tick && !clear &&
                        ((state_q == RAMP_RUN) || (state_q == RAMP_STOPPING));

  // Targets are 0 while stopping, so a channel reaches 0 this step iff it is within one step of it.
  always_comb begin
    all_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rate_out[i] > STEP) all_low = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      RAMP_DISARMED: begin
        if (arm_req) begin
          state_d   = RAMP_ARMING;
          arm_cnt_d = '0;
        end
      end
      RAMP_ARMING: begin
        if (!arm_req) begin
          state_d = RAMP_DISARMED;
        end else if (step_tick) begin
          if (arm_cnt_q == ARM_LAST) state_d = RAMP_RUN;
          else                       arm_cnt_d = arm_cnt_q + ACW'(1);
        end
      end
      RAMP_RUN: begin
        if (!arm_req) state_d = RAMP_STOPPING;
      end
      RAMP_STOPPING: begin
        if (step_tick && all_low) state_d = RAMP_DISARMED;
      end
      default: state_d = RAMP_DISARMED;
    endcase
  end

  assign armed_d = (state_d == RAMP_RUN);

  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      state_q      <= RAMP_DISARMED;
      period_cnt_q <= '0;
      arm_cnt_q    <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      arm_cnt_q    <= arm_cnt_d;
      armed_q      <= armed_d;
    end
  end

  assign cmd_rate[0] = bus.cmd_rate_1;
  assign cmd_rate[1] = bus.cmd_rate_2;
  assign cmd_rate[2] = bus.cmd_rate_3;
  assign cmd_rate[3] = bus.cmd_rate_4;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    rate_slew_channel #(.MAX_STEP(MAX_STEP)) u_ch (
      .us_clk (us_clk),
      .resetn (resetn),
      .load   (load),
      .target (cmd_rate[i]),
      .step   (step_en),
      .clear  (clear),
      .out    (rate_out[i])
    );
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.step_tick    = step_tick;
  assign bus.armed        = armed_q;
  assign bus.motor_1_rate = rate_out[0];
  assign bus.motor_2_rate = rate_out[1];
  assign bus.motor_3_rate = rate_out[2];
  assign bus.motor_4_rate = rate_out[3];

endmodule
